// File: rtl/bus_arbiter.sv
// bus_arbiter: four-master round-robin bus arbiter with optional hold limit
module bus_arbiter #(
    parameter int unsigned MAX_HOLD = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_req_,
    input  logic       m1_req_,
    input  logic       m2_req_,
    input  logic       m3_req_,
    output logic       m0_grnt_,
    output logic       m1_grnt_,
    output logic       m2_grnt_,
    output logic       m3_grnt_,
    output logic [1:0] m_owner
);
    logic [3:0] req;
    logic [1:0] owner_q, owner_d, nxt;
    logic [7:0] hold_q, hold_d;
    logic [3:0] grnt_q;
    logic       found, move;
    assign req = ~{m3_req_, m2_req_, m1_req_, m0_req_};
    assign {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = grnt_q;
    assign m_owner = owner_q;
    // Rotating search from owner+1; the largest offset is visited first so the nearest requester wins.
    // The hold limit compares with >= so a long solo hold cannot skip past the limit and starve late requesters.
    always_comb begin
        nxt   = owner_q;
        found = 1'b0;
        for (int i = 3; i >= 1; i--) begin
            if (req[owner_q + 2'(i)]) begin
                nxt   = owner_q + 2'(i);
                found = 1'b1;
            end
        end
        move    = !req[owner_q] || (MAX_HOLD != 0 && hold_q >= 8'(MAX_HOLD - 1) && found);
        owner_d = move ? nxt : owner_q;
        hold_d  = move ? 8'd0 : (hold_q == 8'hFF ? hold_q : hold_q + 8'd1);
    end
    // Owner, hold counter and one-hot-low grants all update on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= 2'd0;
            hold_q  <= 8'd0;
            grnt_q  <= 4'b1110;
        end else begin
            owner_q <= owner_d;
            hold_q  <= hold_d;
            grnt_q  <= ~(4'b0001 << owner_d);
        end
    end
endmodule
